// File: rtl/fi_pkg.sv
// Shared types and constants for the fault-injection campaign sequencer.
package fi_pkg;

   typedef enum logic [2:0] {
      StIdle, StDraw, StWaitTrig, StDelay, StInject, StWaitEnd, StSocRst, StSettle
   } fi_state_e;

   // Right-shifting Galois taps for x^32+x^22+x^2+x+1.
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

   // Entry 0 is listed last so it lands in the lowest slice.
   localparam logic [6:0][4:0] REG_TABLE = {5'd23, 5'd22, 5'd21, 5'd20, 5'd19, 5'd18, 5'd9};

   function automatic logic [4:0] reg_sel(input logic [2:0] idx);
      logic [2:0] i;
      i = (idx == 3'd7) ? 3'd0 : idx;
      return REG_TABLE[i];
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/fi_lfsr.sv
// 32-bit Galois LFSR; load restores the seed, adv steps once.
module fi_lfsr #(
   parameter logic [31:0] SEED = 32'hACE1_2024
) (
   input  logic        clk,
   input  logic        load,
   input  logic        adv,
   output logic [31:0] value
);
   import fi_pkg::*;

   logic [31:0] state_q, state_d;

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = SEED;
      end else if (adv) begin
         state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? LFSR_POLY : 32'h0);
      end
   end

   always_ff @(posedge clk) begin
      state_q <= state_d;
   end

   assign value = state_q;

endmodule

// File: rtl/fi_campaign_ctrl.sv
// Fault-injection campaign sequencer: draws an injection per experiment, fires the
// fault strobe, classifies the outcome and holds the SoC in reset between runs.
module fi_campaign_ctrl
   import fi_pkg::*;
#(
   parameter int unsigned NEXP       = 10,
   parameter int unsigned FR         = 50,
   parameter logic [31:0] TIMEOUT    = 32'h0000_C000,
   parameter int unsigned DELAY_MIN  = 900,
   parameter int unsigned DELAY_LOG2 = 12,
   parameter int unsigned RST_CYCLES = 3,
   parameter logic [31:0] SEED       = 32'hACE1_2024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        trig_i,
   input  logic        done_i,
   output logic        soc_rst_o,
   output logic        fault_en_o,
   output logic [4:0]  fault_bit_o,
   output logic [4:0]  fault_reg_o,
   output logic [15:0] exp_idx_o,
   output logic        busy_o,
   output logic        camp_done_o,
   output logic [15:0] n_inj_o,
   output logic [15:0] n_broken_o,
   output logic [15:0] n_clean_o
);

   // 17-bit threshold so FR=100 covers every 16-bit draw.
   localparam logic [16:0] INJ_THRESH = (FR >= 100) ? 17'd65536 : 17'((FR * 65536) / 100);
   localparam logic [15:0] LAST_IDX   = 16'(NEXP - 1);
   localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);

   fi_state_e   state_q, state_d;
   logic        inj_q, inj_d;
   logic [31:0] delay_q, delay_d, dly_cnt_q, dly_cnt_d, to_cnt_q, to_cnt_d, to_nxt;
   logic [15:0] seq_cnt_q, seq_cnt_d, exp_idx_q, exp_idx_d;
   logic [15:0] n_inj_q, n_inj_d, n_broken_q, n_broken_d, n_clean_q, n_clean_d;
   logic        camp_done_q, camp_done_d;
   logic [4:0]  fault_bit_q, fault_bit_d, fault_reg_q, fault_reg_d;
   logic        soc_rst_q, fault_en_q, busy_q;
   logic        lfsr_adv;
   logic [31:0] rnd;

   fi_lfsr #(.SEED(SEED)) u_lfsr (
      .clk  (clk),
      .load (rst),
      .adv  (lfsr_adv),
      .value(rnd)
   );

   always_comb begin
      state_d     = state_q;
      inj_d       = inj_q;
      delay_d     = delay_q;
      dly_cnt_d   = dly_cnt_q;
      to_cnt_d    = to_cnt_q;
      seq_cnt_d   = seq_cnt_q;
      exp_idx_d   = exp_idx_q;
      n_inj_d     = n_inj_q;
      n_broken_d  = n_broken_q;
      n_clean_d   = n_clean_q;
      camp_done_d = camp_done_q;
      fault_bit_d = fault_bit_q;
      fault_reg_d = fault_reg_q;
      lfsr_adv    = 1'b0;
      to_nxt      = to_cnt_q + 32'd1;

      if (state_q inside {StDelay, StInject, StWaitEnd}) begin
         to_cnt_d = to_nxt;
      end

      case (state_q)
         StIdle: begin
            if (start) begin
               exp_idx_d   = '0;
               n_inj_d     = '0;
               n_broken_d  = '0;
               n_clean_d   = '0;
               camp_done_d = 1'b0;
               state_d     = StDraw;
            end
         end
         StDraw: begin
            inj_d       = ({1'b0, rnd[15:0]} < INJ_THRESH);
            delay_d     = 32'(DELAY_MIN) + 32'(rnd[16 +: DELAY_LOG2]);
            fault_bit_d = rnd[31:27];
            fault_reg_d = reg_sel(rnd[26:24]);
            lfsr_adv    = 1'b1;
            state_d     = StWaitTrig;
         end
         StWaitTrig: begin
            if (trig_i) begin
               to_cnt_d  = '0;
               dly_cnt_d = delay_q;
               if (!inj_q) begin
                  state_d = StWaitEnd;
               end else if (delay_q == 32'd0) begin
                  state_d = StInject;
               end else begin
                  state_d = StDelay;
               end
            end
         end
         StDelay: begin
            dly_cnt_d = dly_cnt_q - 32'd1;
            if (done_i) begin
               n_clean_d = sat_inc(n_clean_q);
               seq_cnt_d = '0;
               state_d   = StSocRst;
            end else if (dly_cnt_q == 32'd1) begin
               state_d = StInject;
            end
         end
         StInject: begin
            n_inj_d = sat_inc(n_inj_q);
            state_d = StWaitEnd;
         end
         StWaitEnd: begin
            // A completion in the timeout cycle still counts as clean.
            if (done_i) begin
               n_clean_d = sat_inc(n_clean_q);
               seq_cnt_d = '0;
               state_d   = StSocRst;
            end else if (to_nxt >= TIMEOUT) begin
               n_broken_d = sat_inc(n_broken_q);
               seq_cnt_d  = '0;
               state_d    = StSocRst;
            end
         end
         StSocRst: begin
            if (seq_cnt_q == RST_LAST) begin
               seq_cnt_d = '0;
               state_d   = StSettle;
            end else begin
               seq_cnt_d = seq_cnt_q + 16'd1;
            end
         end
         StSettle: begin
            if (seq_cnt_q == 16'd1) begin
               if (exp_idx_q == LAST_IDX) begin
                  camp_done_d = 1'b1;
                  state_d     = StIdle;
               end else begin
                  exp_idx_d = exp_idx_q + 16'd1;
                  state_d   = StDraw;
               end
            end else begin
               seq_cnt_d = seq_cnt_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         inj_q       <= 1'b0;
         delay_q     <= '0;
         dly_cnt_q   <= '0;
         to_cnt_q    <= '0;
         seq_cnt_q   <= '0;
         exp_idx_q   <= '0;
         n_inj_q     <= '0;
         n_broken_q  <= '0;
         n_clean_q   <= '0;
         camp_done_q <= 1'b0;
         fault_bit_q <= '0;
         fault_reg_q <= '0;
         soc_rst_q   <= 1'b1;
         fault_en_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         inj_q       <= inj_d;
         delay_q     <= delay_d;
         dly_cnt_q   <= dly_cnt_d;
         to_cnt_q    <= to_cnt_d;
         seq_cnt_q   <= seq_cnt_d;
         exp_idx_q   <= exp_idx_d;
         n_inj_q     <= n_inj_d;
         n_broken_q  <= n_broken_d;
         n_clean_q   <= n_clean_d;
         camp_done_q <= camp_done_d;
         fault_bit_q <= fault_bit_d;
         fault_reg_q <= fault_reg_d;
         soc_rst_q   <= (state_d == StSocRst);
         fault_en_q  <= (state_d == StInject);
         busy_q      <= (state_d != StIdle);
      end
   end

   assign soc_rst_o   = soc_rst_q;
   assign fault_en_o  = fault_en_q;
   assign fault_bit_o = fault_bit_q;
   assign fault_reg_o = fault_reg_q;
   assign exp_idx_o   = exp_idx_q;
   assign busy_o      = busy_q;
   assign camp_done_o = camp_done_q;
   assign n_inj_o     = n_inj_q;
   assign n_broken_o  = n_broken_q;
   assign n_clean_o   = n_clean_q;

endmodule

// File: tb/tb_fi_campaign_ctrl.sv
// Directed bench: dut_a always injects (single experiment), dut_b never injects (three).
module tb_fi_campaign_ctrl;

   localparam logic [31:0] SEED = 32'hACE1_2024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, start_a, trig_a, done_a, rst_b, start_b, trig_b, done_b;
   logic        soc_rst_a, fault_en_a, busy_a, camp_done_a;
   logic        soc_rst_b, fault_en_b, busy_b, camp_done_b;
   logic [4:0]  fault_bit_a, fault_reg_a, fault_bit_b, fault_reg_b;
   logic [15:0] exp_idx_a, n_inj_a, n_broken_a, n_clean_a;
   logic [15:0] exp_idx_b, n_inj_b, n_broken_b, n_clean_b;

   int checks = 0;
   int errors = 0;
   logic [31:0] lfsr_a;

   fi_campaign_ctrl #(
      .NEXP(1), .FR(100), .TIMEOUT(32'd100), .DELAY_MIN(4), .DELAY_LOG2(1),
      .RST_CYCLES(3), .SEED(SEED)
   ) dut_a (
      .clk(clk), .rst(rst_a), .start(start_a), .trig_i(trig_a), .done_i(done_a),
      .soc_rst_o(soc_rst_a), .fault_en_o(fault_en_a), .fault_bit_o(fault_bit_a),
      .fault_reg_o(fault_reg_a), .exp_idx_o(exp_idx_a), .busy_o(busy_a),
      .camp_done_o(camp_done_a), .n_inj_o(n_inj_a), .n_broken_o(n_broken_a),
      .n_clean_o(n_clean_a)
   );

   fi_campaign_ctrl #(
      .NEXP(3), .FR(0), .TIMEOUT(32'd100), .DELAY_MIN(4), .DELAY_LOG2(1),
      .RST_CYCLES(3), .SEED(SEED)
   ) dut_b (
      .clk(clk), .rst(rst_b), .start(start_b), .trig_i(trig_b), .done_i(done_b),
      .soc_rst_o(soc_rst_b), .fault_en_o(fault_en_b), .fault_bit_o(fault_bit_b),
      .fault_reg_o(fault_reg_b), .exp_idx_o(exp_idx_b), .busy_o(busy_b),
      .camp_done_o(camp_done_b), .n_inj_o(n_inj_b), .n_broken_o(n_broken_b),
      .n_clean_o(n_clean_b)
   );

   function automatic logic [31:0] lfsr_step(input logic [31:0] r);
      return {1'b0, r[31:1]} ^ (r[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   function automatic logic [4:0] tb_reg(input logic [2:0] i);
      case (i)
         3'd1: return 5'd18;
         3'd2: return 5'd19;
         3'd3: return 5'd20;
         3'd4: return 5'd21;
         3'd5: return 5'd22;
         3'd6: return 5'd23;
         default: return 5'd9;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench observing the DUT's first WAIT_TRIG cycle.
   task automatic start_campaign(input bit sel);
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      tick();
      start_a = 1'b0;
      start_b = 1'b0;
      tick();
   endtask

   // Raises trig now (cycle T); k counts observed cycles after T. Returns at first SETTLE cycle.
   task automatic run_exp(input bit sel, input int done_at, output int end_k, output int rlen,
                          output int nf, output int fk);
      logic sr, fe;
      end_k = -1; rlen = 0; nf = 0; fk = -1;
      if (sel) trig_b = 1'b1; else trig_a = 1'b1;
      for (int k = 1; k <= 400; k++) begin
         tick();
         if (k == done_at) begin
            if (sel) done_b = 1'b1; else done_a = 1'b1;
         end
         sr = sel ? soc_rst_b : soc_rst_a;
         fe = sel ? fault_en_b : fault_en_a;
         if (fe) begin
            nf++;
            if (fk < 0) fk = k;
         end
         if (sr) begin
            if (end_k < 0) begin
               end_k = k;
               if (sel) begin trig_b = 1'b0; done_b = 1'b0; end
               else begin trig_a = 1'b0; done_a = 1'b0; end
            end
            rlen++;
         end else if (end_k >= 0) begin
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1;
      tick(); tick();
      checks++; if (soc_rst_a !== 1'b1) begin errors++; $display("FAIL reset_soc_rst_a: got %b expected 1", soc_rst_a); end
      checks++; if (soc_rst_b !== 1'b1) begin errors++; $display("FAIL reset_soc_rst_b: got %b expected 1", soc_rst_b); end
      checks++; if ({busy_a, fault_en_a, camp_done_a} !== 3'b000) begin errors++; $display("FAIL reset_flags_a: got %b expected 000", {busy_a, fault_en_a, camp_done_a}); end
      checks++; if ({n_inj_b, n_broken_b, n_clean_b, exp_idx_b} !== 64'd0) begin errors++; $display("FAIL reset_counts_b: got %h expected 0", {n_inj_b, n_broken_b, n_clean_b, exp_idx_b}); end
      checks++; if ({fault_bit_a, fault_reg_a} !== 10'd0) begin errors++; $display("FAIL reset_fields_a: got %h expected 0", {fault_bit_a, fault_reg_a}); end
      rst_a = 1'b0; rst_b = 1'b0;
      tick();
      checks++; if ({soc_rst_a, soc_rst_b} !== 2'b00) begin errors++; $display("FAIL reset_release: got %b expected 00", {soc_rst_a, soc_rst_b}); end
      lfsr_a = SEED;
   endtask

   task automatic test_inject();
      int end_k, rlen, nf, fk;
      logic [31:0] r;
      r = lfsr_a;
      lfsr_a = lfsr_step(lfsr_a);
      start_campaign(1'b0);
      run_exp(1'b0, 20, end_k, rlen, nf, fk);
      checks++; if (fk != 5 + int'(r[16])) begin errors++; $display("FAIL inject_time: got T+%0d expected T+%0d", fk, 5 + int'(r[16])); end
      checks++; if (nf != 1) begin errors++; $display("FAIL inject_pulses: got %0d expected 1", nf); end
      checks++; if (end_k != 21 || rlen != 3) begin errors++; $display("FAIL inject_end: got end %0d len %0d expected 21/3", end_k, rlen); end
      checks++; if (fault_bit_a !== r[31:27]) begin errors++; $display("FAIL inject_bit: got %0d expected %0d", fault_bit_a, r[31:27]); end
      checks++; if (fault_reg_a !== tb_reg(r[26:24])) begin errors++; $display("FAIL inject_reg: got %0d expected %0d", fault_reg_a, tb_reg(r[26:24])); end
      tick(); tick();
      checks++; if ({camp_done_a, busy_a} !== 2'b10) begin errors++; $display("FAIL inject_camp_done: got %b expected 10", {camp_done_a, busy_a}); end
      checks++; if (n_inj_a !== 16'd1 || n_clean_a !== 16'd1) begin errors++; $display("FAIL inject_counts: got inj %0d clean %0d expected 1/1", n_inj_a, n_clean_a); end
   endtask

   task automatic test_done_in_delay();
      int end_k, rlen, nf, fk;
      lfsr_a = lfsr_step(lfsr_a);
      start_campaign(1'b0);
      run_exp(1'b0, 2, end_k, rlen, nf, fk);
      checks++; if (nf != 0) begin errors++; $display("FAIL delay_abort_pulses: got %0d expected 0", nf); end
      checks++; if (end_k != 3) begin errors++; $display("FAIL delay_abort_end: got T+%0d expected T+3", end_k); end
      tick(); tick();
      checks++; if (n_inj_a !== 16'd0 || n_clean_a !== 16'd1) begin errors++; $display("FAIL delay_abort_counts: got inj %0d clean %0d expected 0/1", n_inj_a, n_clean_a); end
   endtask

   task automatic test_rst_mid();
      lfsr_a = lfsr_step(lfsr_a);
      start_campaign(1'b0);
      trig_a = 1'b1;
      repeat (8) tick();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      checks++; if (n_inj_a !== 16'd1 || busy_a !== 1'b1) begin errors++; $display("FAIL start_ignored: got inj %0d busy %b expected 1/1", n_inj_a, busy_a); end
      rst_a = 1'b1;
      tick();
      checks++; if ({soc_rst_a, busy_a, fault_en_a} !== 3'b100) begin errors++; $display("FAIL rst_mid_flags: got %b expected 100", {soc_rst_a, busy_a, fault_en_a}); end
      checks++; if ({n_inj_a, n_clean_a, n_broken_a, fault_bit_a} !== 53'd0) begin errors++; $display("FAIL rst_mid_counts: got %h expected 0", {n_inj_a, n_clean_a, n_broken_a, fault_bit_a}); end
      rst_a = 1'b0; trig_a = 1'b0;
      tick();
      checks++; if ({soc_rst_a, busy_a} !== 2'b00) begin errors++; $display("FAIL rst_mid_release: got %b expected 00", {soc_rst_a, busy_a}); end
      lfsr_a = SEED;
   endtask

   task automatic test_clean_campaign();
      int end_k, rlen, nf, fk;
      start_campaign(1'b1);
      for (int e = 0; e < 3; e++) begin
         checks++; if (exp_idx_b !== 16'(e)) begin errors++; $display("FAIL clean_exp_idx: got %0d expected %0d", exp_idx_b, e); end
         run_exp(1'b1, 20, end_k, rlen, nf, fk);
         checks++; if (end_k != 21 || rlen != 3 || nf != 0) begin errors++; $display("FAIL clean_run: got end %0d len %0d pulses %0d expected 21/3/0", end_k, rlen, nf); end
         if (e < 2) repeat (3) tick();
      end
      tick(); tick();
      checks++; if ({camp_done_b, busy_b} !== 2'b10) begin errors++; $display("FAIL clean_camp_done: got %b expected 10", {camp_done_b, busy_b}); end
      checks++; if (n_clean_b !== 16'd3 || n_inj_b !== 16'd0 || n_broken_b !== 16'd0) begin errors++; $display("FAIL clean_counts: got clean %0d inj %0d broken %0d expected 3/0/0", n_clean_b, n_inj_b, n_broken_b); end
   endtask

   task automatic test_timeout();
      int end_k, rlen, nf, fk;
      start_campaign(1'b1);
      checks++; if ({camp_done_b, n_clean_b} !== 17'd0) begin errors++; $display("FAIL restart_clear: got %h expected 0", {camp_done_b, n_clean_b}); end
      run_exp(1'b1, 0, end_k, rlen, nf, fk);
      checks++; if (end_k != 101) begin errors++; $display("FAIL timeout_time: got T+%0d expected T+101", end_k); end
      checks++; if (n_broken_b !== 16'd1 || n_clean_b !== 16'd0) begin errors++; $display("FAIL timeout_counts: got broken %0d clean %0d expected 1/0", n_broken_b, n_clean_b); end
      repeat (3) tick();
   endtask

   task automatic test_done_and_timeout();
      int end_k, rlen, nf, fk;
      run_exp(1'b1, 100, end_k, rlen, nf, fk);
      checks++; if (end_k != 101) begin errors++; $display("FAIL tie_time: got T+%0d expected T+101", end_k); end
      checks++; if (n_clean_b !== 16'd1 || n_broken_b !== 16'd1) begin errors++; $display("FAIL tie_counts: got clean %0d broken %0d expected 1/1", n_clean_b, n_broken_b); end
      repeat (3) tick();
      run_exp(1'b1, 5, end_k, rlen, nf, fk);
      checks++; if (end_k != 6) begin errors++; $display("FAIL early_done_time: got T+%0d expected T+6", end_k); end
      tick(); tick();
      checks++; if (camp_done_b !== 1'b1 || n_clean_b !== 16'd2) begin errors++; $display("FAIL tie_campaign_end: got done %b clean %0d expected 1/2", camp_done_b, n_clean_b); end
   endtask

   initial begin
      start_a = 1'b0; trig_a = 1'b0; done_a = 1'b0;
      start_b = 1'b0; trig_b = 1'b0; done_b = 1'b0;
      test_reset();
      test_inject();
      test_done_in_delay();
      test_rst_mid();
      // LFSR was reseeded, so the first draw repeats.
      test_inject();
      test_clean_campaign();
      test_timeout();
      test_done_and_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/fi_campaign_ctrl.md
# fi_campaign_ctrl

Hardware sequencer for fault-injection campaigns on the redundant SoC, used in FPGA runs where no simulator testbench drives the experiments. For each of `NEXP` experiments it waits for the protected workload to start, draws a pseudo-random inject decision, delay, bit and register target, fires a one-cycle fault strobe into the primary CPU's fault hook, then waits for completion or timeout. It then holds the SoC in reset so firmware can be reloaded. It sits beside the SoC top, observing `leds[1]` (workload running) and `leds[0]` (workload done), and owns the SoC reset.

## Interface
- `NEXP`, 10: number of experiments per campaign (1..65535)
- `FR`, 50: fault probability in percent (0..100)
- `TIMEOUT`, 32'h0000C000: cycles after trigger before the experiment is declared broken
- `DELAY_MIN`, 900: minimum injection delay in cycles
- `DELAY_LOG2`, 12: random delay span, 0..2^DELAY_LOG2-1, added to `DELAY_MIN`
- `RST_CYCLES`, 3: SoC reset pulse length in cycles (>=1)
- `SEED`, 32'hACE1_2024: LFSR seed (nonzero)

Ports:
- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `start` in 1: campaign start, sampled in IDLE only
- `trig_i` in 1: workload running (`leds[1]`)
- `done_i` in 1: workload finished (`leds[0]`)
- `soc_rst_o` out 1: active-high SoC reset / firmware-reload window
- `fault_en_o` out 1: one-cycle injection strobe
- `fault_bit_o` out 5: bit to corrupt
- `fault_reg_o` out 5: target register index (one of 9, 18..23)
- `exp_idx_o` out 16: current experiment number
- `busy_o` out 1: campaign in progress
- `camp_done_o` out 1: campaign complete, sticky until next `start`
- `n_inj_o`, `n_broken_o`, `n_clean_o` out 16 each: saturating counters for injected runs, timed-out runs and runs ending on `done_i`

## Operation
- States: IDLE, DRAW, WAIT_TRIG, DELAY, INJECT, WAIT_END, SOC_RST, SETTLE.
- IDLE: when `start`=1, clear counters, `exp_idx`, and `camp_done`, then go to DRAW. `start` is ignored in every other state.
- DRAW, one cycle: latch the fields from the current LFSR word `r`, then advance the LFSR.
  - `inj = (r[15:0] < FR*65536/100)`
  - `delay = DELAY_MIN + r[16+DELAY_LOG2-1:16]`
  - `bit = r[31:27]`
  - `reg` = table index `r[26:24]`, with value 7 mapping to entry 0
  - Table: {9,18,19,20,21,22,23}.
  - Go to WAIT_TRIG.
- WAIT_TRIG: when `trig_i`=1 (cycle T), clear the timeout counter. If `inj`, go to DELAY; otherwise go to WAIT_END.
- DELAY: decrement the loaded delay each cycle; at zero go to INJECT. If `done_i` arrives first, abort the injection, count the run as clean, and go to SOC_RST.
- INJECT: `fault_en_o`=1 for exactly one cycle; increment `n_inj`; go to WAIT_END.
- WAIT_END:
  - `done_i` → count clean, go to SOC_RST.
  - Timeout counter reaches `TIMEOUT` → count broken, go to SOC_RST.
  - Both in the same cycle → `done_i` wins.
- SOC_RST: `soc_rst_o`=1 for `RST_CYCLES` cycles, then go to SETTLE.
- SETTLE: 2 cycles. Then, if `exp_idx == NEXP-1`, set `camp_done` and go to IDLE; otherwise increment `exp_idx` and go to DRAW.
- The timeout counter (32 bits) runs from cycle T in the DELAY, INJECT and WAIT_END states.
- `fault_bit_o` and `fault_reg_o` hold the drawn values from DRAW until the next DRAW.
- Counters saturate at 16'hFFFF.
- `FR`=0 never injects. `FR`=100 always injects, because the threshold is clamped to 65536 and the compare is 17-bit.

## Timing
- Reset values:
  - State IDLE; LFSR = `SEED`.
  - `soc_rst_o`=1 during `rst` and 0 from the first cycle after it.
  - All other outputs 0.
- `rst` mid-campaign aborts immediately; no partial counter update.
- `fault_en_o` rises on cycle T+1+delay, where T is the first cycle `trig_i` is sampled high in WAIT_TRIG.
- Broken detection occurs at cycle T+1+`TIMEOUT` if `done_i` never rose.
- All outputs are registered. `busy_o` is 1 in every state except IDLE.
- `trig_i` high before WAIT_TRIG is entered is accepted on WAIT_TRIG's first cycle.

## Structure
- Package `fi_pkg`:
  - State enum.
  - LFSR polynomial 32'h8020_0003 (Galois form of x^32+x^22+x^2+x+1).
  - Register-index table constant.
- Sub-module `fi_lfsr`: 32-bit Galois LFSR with seed load and advance enable.
- Remaining logic in the top: FSM, delay/timeout counters, statistics.

## Test plan
- `FR`=100, `NEXP`=1, `DELAY_MIN`=4, `DELAY_LOG2`=1: raise `trig_i` at T → `fault_en_o` pulses once at T+5 or T+6 and matches the reference-model LFSR draw; `n_inj`=1.
- `FR`=0, `NEXP`=3, `done_i` 20 cycles after each trigger → `n_inj`=0, `n_clean`=3, `camp_done_o`=1, three `soc_rst_o` pulses each 3 cycles long.
- `TIMEOUT`=100, `done_i` never asserted → `n_broken` increments at T+101, then `soc_rst_o` asserts.
- `done_i` and timeout in the same cycle → `n_clean`+1, `n_broken` unchanged.
- `done_i` during DELAY → no `fault_en_o`, `n_clean`+1, `n_inj` unchanged.
- `rst` asserted in WAIT_END → next cycle state IDLE, counters 0, `soc_rst_o`=1 then 0; `start` pulsed while busy → ignored.
